payment_fsm: RTL and testbench
==============================

Name: payment_fsm

Overview:
Clocked, parametrised payment controller for the vending datapath. It runs a purchase session: it latches the price, accumulates coin strobes, and counts down a session timer driven by an external 1 Hz tick. It closes the session on cancel, on timeout or, optionally, as soon as the price is covered. It then reports success or failure, the change or refund amount, and BCD digits of the amount paid for the display driver.

Parameters:
AMT_W, 8, width of price/paid/change in currency units
COIN_W, 4, width of a single coin value
TIMEOUT_S, 30, session length in sec_tick strobes (1..63)
AUTO_FINISH, 1, 1 = settle as soon as paid >= price; 0 = settle only on cancel/timeout

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse; opens a session when idle
price  in  AMT_W  amount due; sampled on accepted start
coin_valid  in  1  one-cycle strobe, one coin
coin_val  in  COIN_W  value of the strobed coin
cancel  in  1  level/pulse; requests settlement
sec_tick  in  1  one-cycle 1 Hz strobe
busy  out  1  session open (COLLECT or SETTLE)
paid  out  AMT_W  running amount paid
paid_ones  out  4  BCD ones digit of paid
paid_tens  out  4  BCD tens digit of paid
paid_hund  out  4  BCD hundreds digit of paid
remain_s  out  6  seconds left in session
coin_reject  out  1  one-cycle pulse; coin refused (overflow)
done_ok  out  1  one-cycle pulse; purchase succeeded
done_fail  out  1  one-cycle pulse; purchase failed
change  out  AMT_W  change (on ok) or full refund (on fail); held until next accepted start

Behaviour:
- Reset (synchronous, active-high, also mid-session): state IDLE; all outputs 0; paid, change and the latched price cleared; an in-flight session is discarded with no done pulse.
- States: IDLE, COLLECT, SETTLE, DONE.
- IDLE: start=1 -> next cycle COLLECT, paid=0, change=0, remain_s=TIMEOUT_S, price latched. Coins, cancel and ticks are ignored in IDLE.
- COLLECT, coin accept: coin_valid adds coin_val to paid with 1-cycle latency.
- COLLECT, overflow: if paid+coin_val > 2^AMT_W-1, the coin is refused; paid is unchanged and coin_reject pulses the next cycle.
- COLLECT, timer: sec_tick decrements remain_s. A tick when remain_s==1 is a timeout; remain_s shows 0.
- COLLECT, exits to SETTLE on any of: cancel; timeout; AUTO_FINISH=1 and (paid + accepted coin) >= price.
- Simultaneous events in one cycle: the coin is always counted before the exit decision. cancel, timeout and auto-finish together produce one transition only.
- start in COLLECT, SETTLE or DONE: ignored.
- SETTLE (1 cycle):
  - paid >= price -> change = paid - price, done_ok = 1 next cycle. This holds even on cancel or timeout.
  - paid < price -> change = paid, done_fail = 1.
- Zero price: price==0 with AUTO_FINISH=1 -> SETTLE on the first COLLECT cycle, done_ok, change 0.
- DONE (1 cycle): done pulse asserted -> IDLE. change and paid hold their values until the next accepted start.
- busy: 1 in COLLECT and SETTLE, 0 otherwise.
- BCD digits: combinational from registered paid. Values above 999 cannot occur for AMT_W <= 9. For AMT_W > 9 the display saturates at 999.
- Arithmetic: all unsigned; comparisons are done at AMT_W+1 bits so they never wrap.

Decomposition:
- Shared package pay_pkg: state enum (IDLE/COLLECT/SETTLE/DONE), BCD digit width constant 4, and the default TIMEOUT_S.
- One sub-module, pay_bin2bcd: combinational double-dabble, parametrised by AMT_W, saturating at 999.

Test Plan:
- AUTO_FINISH=1, price=15; coins 5, 5, 10 on separate cycles -> after the third coin: SETTLE, then done_ok pulse, change=5, paid=20, digits 0/2/0.
- price=20; coins 5, 5, then 30 sec_ticks -> remain_s 30 counts down to 0; done_fail; change=10; no done_ok.
- AUTO_FINISH=0, price=20; coins 10, 10, 5, then cancel -> done_ok, change=5. With only a coin of 5 then cancel -> done_fail, change=5.
- AMT_W=6; paid=60, coin 7 -> coin_reject pulse, paid stays 60. coin 3 -> paid=63 accepted.
- coin_valid (val 5), cancel and the final sec_tick in the same cycle at paid=15, price=20 -> coin counted, single done_ok, change=0.
- rst asserted mid-COLLECT with paid=12 -> next cycle all outputs 0, IDLE, no done pulse. A start issued during the session is ignored; a start after returning to IDLE opens a new session normally.

Source files
------------

// File: rtl/pay_pkg.sv
// Shared definitions for the payment controller: session states,
// BCD digit width and the default session length.
package pay_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      SETTLE  = 2'd2,
      DONE    = 2'd3
   } state_e;

   localparam int BCD_W         = 4;
   localparam int TIMEOUT_S_DEF = 30;

endpackage

// File: rtl/pay_bin2bcd.sv
// Combinational binary to three-digit BCD converter (double dabble).
// Inputs above 999 are shown as 999.
module pay_bin2bcd
   import pay_pkg::*;
#(
   parameter int AMT_W = 8
) (
   input  logic [AMT_W-1:0] bin,
   output logic [BCD_W-1:0] ones,
   output logic [BCD_W-1:0] tens,
   output logic [BCD_W-1:0] hund
);

   // At least 10 bits so the 999 clamp value is always representable.
   localparam int W = (AMT_W > 10) ? AMT_W : 10;

   logic [W-1:0] val_w;
   logic [W-1:0] sat;
   logic [11:0]  bcd;

   always_comb begin
      val_w = W'(bin);
      sat   = (val_w > W'(999)) ? W'(999) : val_w;
      bcd   = '0;
      for (int i = W - 1; i >= 0; i--) begin
         for (int d = 0; d < 3; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
               bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
         end
         bcd = {bcd[10:0], sat[i]};
      end
   end

   assign ones = bcd[3:0];
   assign tens = bcd[7:4];
   assign hund = bcd[11:8];

endmodule

// File: rtl/payment_fsm.sv
// Purchase session controller: latches the price, accumulates coins, runs
// the session timer and reports success/failure with change or refund.
module payment_fsm
   import pay_pkg::*;
#(
   parameter int AMT_W       = 8,
   parameter int COIN_W      = 4,
   parameter int TIMEOUT_S   = TIMEOUT_S_DEF,
   parameter int AUTO_FINISH = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [AMT_W-1:0]  price,
   input  logic              coin_valid,
   input  logic [COIN_W-1:0] coin_val,
   input  logic              cancel,
   input  logic              sec_tick,
   output logic              busy,
   output logic [AMT_W-1:0]  paid,
   output logic [BCD_W-1:0]  paid_ones,
   output logic [BCD_W-1:0]  paid_tens,
   output logic [BCD_W-1:0]  paid_hund,
   output logic [5:0]        remain_s,
   output logic              coin_reject,
   output logic              done_ok,
   output logic              done_fail,
   output logic [AMT_W-1:0]  change
);

   state_e           state;
   logic [AMT_W-1:0] price_q;
   logic [AMT_W:0]   coin_sum;
   logic             coin_ok;
   logic [AMT_W-1:0] paid_next;
   logic             timeout;
   logic             covered;
   logic             leave;

   // The coin of this cycle is folded into paid_next before the exit decision.
   always_comb begin
      coin_sum  = {1'b0, paid} + (AMT_W+1)'(coin_val);
      coin_ok   = coin_valid && !coin_sum[AMT_W];
      paid_next = coin_ok ? coin_sum[AMT_W-1:0] : paid;
      timeout   = sec_tick && (remain_s == 6'd1);
      covered   = ({1'b0, paid_next} >= {1'b0, price_q});
      leave     = cancel || timeout || ((AUTO_FINISH != 0) && covered);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         price_q     <= '0;
         paid        <= '0;
         change      <= '0;
         remain_s    <= '0;
         coin_reject <= 1'b0;
         done_ok     <= 1'b0;
         done_fail   <= 1'b0;
      end else begin
         coin_reject <= 1'b0;
         done_ok     <= 1'b0;
         done_fail   <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= COLLECT;
                  price_q  <= price;
                  paid     <= '0;
                  change   <= '0;
                  remain_s <= 6'(TIMEOUT_S);
               end
            end
            COLLECT: begin
               paid        <= paid_next;
               coin_reject <= coin_valid && !coin_ok;
               if (sec_tick && (remain_s != 6'd0)) begin
                  remain_s <= remain_s - 6'd1;
               end
               if (leave) begin
                  state <= SETTLE;
               end
            end
            SETTLE: begin
               if ({1'b0, paid} >= {1'b0, price_q}) begin
                  change  <= paid - price_q;
                  done_ok <= 1'b1;
               end else begin
                  change    <= paid;
                  done_fail <= 1'b1;
               end
               state <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state == COLLECT) || (state == SETTLE);

   pay_bin2bcd #(
      .AMT_W (AMT_W)
   ) u_bcd (
      .bin  (paid),
      .ones (paid_ones),
      .tens (paid_tens),
      .hund (paid_hund)
   );

endmodule

// File: tb/tb_payment_fsm.sv
// Scoreboard bench: instance A (AMT_W=8, auto-finish) and instance B
// (AMT_W=6, settle on cancel/timeout only) driven from one stimulus thread.
module tb_payment_fsm;

   typedef struct {
      bit ok;
      int change;
      int paid;
   } exp_t;

   logic       clk;
   logic       rst;

   logic       start_a, coin_valid_a, cancel_a, tick_a;
   logic [7:0] price_a;
   logic [3:0] coin_val_a;
   logic       busy_a, coin_reject_a, done_ok_a, done_fail_a;
   logic [7:0] paid_a, change_a;
   logic [3:0] ones_a, tens_a, hund_a;
   logic [5:0] remain_a;

   logic       start_b, coin_valid_b, cancel_b, tick_b;
   logic [5:0] price_b;
   logic [3:0] coin_val_b;
   logic       busy_b, coin_reject_b, done_ok_b, done_fail_b;
   logic [5:0] paid_b, change_b;
   logic [3:0] ones_b, tens_b, hund_b;
   logic [5:0] remain_b;

   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   int m_paid[2];
   int m_price[2];
   int m_remain[2];
   int last_change[2];
   int max_amt[2] = '{255, 63};
   bit af[2]      = '{1'b1, 1'b0};

   payment_fsm #(.AMT_W(8), .COIN_W(4), .TIMEOUT_S(30), .AUTO_FINISH(1)) u_a (
      .clk(clk), .rst(rst), .start(start_a), .price(price_a),
      .coin_valid(coin_valid_a), .coin_val(coin_val_a), .cancel(cancel_a),
      .sec_tick(tick_a), .busy(busy_a), .paid(paid_a), .paid_ones(ones_a),
      .paid_tens(tens_a), .paid_hund(hund_a), .remain_s(remain_a),
      .coin_reject(coin_reject_a), .done_ok(done_ok_a), .done_fail(done_fail_a),
      .change(change_a)
   );

   payment_fsm #(.AMT_W(6), .COIN_W(4), .TIMEOUT_S(30), .AUTO_FINISH(0)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .price(price_b),
      .coin_valid(coin_valid_b), .coin_val(coin_val_b), .cancel(cancel_b),
      .sec_tick(tick_b), .busy(busy_b), .paid(paid_b), .paid_ones(ones_b),
      .paid_tens(tens_b), .paid_hund(hund_b), .remain_s(remain_b),
      .coin_reject(coin_reject_b), .done_ok(done_ok_b), .done_fail(done_fail_b),
      .change(change_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic int rd_busy(input int sel);
      return (sel != 0) ? int'(busy_b) : int'(busy_a);
   endfunction
   function automatic int rd_paid(input int sel);
      return (sel != 0) ? int'(paid_b) : int'(paid_a);
   endfunction
   function automatic int rd_change(input int sel);
      return (sel != 0) ? int'(change_b) : int'(change_a);
   endfunction
   function automatic int rd_remain(input int sel);
      return (sel != 0) ? int'(remain_b) : int'(remain_a);
   endfunction
   function automatic int rd_rej(input int sel);
      return (sel != 0) ? int'(coin_reject_b) : int'(coin_reject_a);
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int sel, input bit st, input int pr, input bit cv,
                        input int cval, input bit cn, input bit tk);
      if (sel == 0) begin
         start_a = st; price_a = 8'(pr); coin_valid_a = cv;
         coin_val_a = 4'(cval); cancel_a = cn; tick_a = tk;
      end else begin
         start_b = st; price_b = 6'(pr); coin_valid_b = cv;
         coin_val_b = 4'(cval); cancel_b = cn; tick_b = tk;
      end
   endtask

   task automatic push_exp(input int sel);
      exp_t e;
      e.ok     = (m_paid[sel] >= m_price[sel]);
      e.change = e.ok ? (m_paid[sel] - m_price[sel]) : m_paid[sel];
      e.paid   = m_paid[sel];
      last_change[sel] = e.change;
      if (sel == 0) q_a.push_back(e);
      else q_b.push_back(e);
   endtask

   task automatic start_s(input int sel, input int pr);
      drive(sel, 1'b1, pr, 1'b0, 0, 1'b0, 1'b0);
      cycle();
      drive(sel, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
      m_paid[sel] = 0;
      m_price[sel] = pr;
      m_remain[sel] = 30;
      check("start_busy", rd_busy(sel), 1);
      check("start_paid", rd_paid(sel), 0);
      check("start_change", rd_change(sel), 0);
      check("start_remain", rd_remain(sel), 30);
      if (af[sel] && pr == 0) push_exp(sel);
   endtask

   task automatic coin(input int sel, input int val);
      bit acc;
      drive(sel, 1'b0, 0, 1'b1, val, 1'b0, 1'b0);
      cycle();
      drive(sel, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
      acc = (m_paid[sel] + val <= max_amt[sel]);
      if (acc) m_paid[sel] += val;
      check("coin_reject", rd_rej(sel), acc ? 0 : 1);
      check("coin_paid", rd_paid(sel), m_paid[sel]);
      if (af[sel] && m_paid[sel] >= m_price[sel]) push_exp(sel);
   endtask

   task automatic ticks(input int sel, input int n);
      for (int i = 0; i < n; i++) begin
         drive(sel, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
         cycle();
         drive(sel, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
         m_remain[sel]--;
         check("remain_s", rd_remain(sel), m_remain[sel]);
         if (m_remain[sel] == 0) push_exp(sel);
      end
   endtask

   task automatic cancel_s(input int sel);
      drive(sel, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
      cycle();
      drive(sel, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
      push_exp(sel);
   endtask

   // Coin, cancel and the final tick all in one cycle.
   task automatic combo(input int sel, input int val);
      drive(sel, 1'b0, 0, 1'b1, val, 1'b1, 1'b1);
      cycle();
      drive(sel, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
      m_paid[sel] += val;
      m_remain[sel]--;
      check("combo_paid", rd_paid(sel), m_paid[sel]);
      check("combo_remain", rd_remain(sel), m_remain[sel]);
      push_exp(sel);
   endtask

   task automatic wait_idle(input int sel);
      int n = 0;
      while (rd_busy(sel) == 1 && n < 10) begin
         cycle();
         n++;
      end
      check("settle_in_time", (n < 10) ? 1 : 0, 1);
      cycle();
      check("idle_busy", rd_busy(sel), 0);
      check("change_hold", rd_change(sel), last_change[sel]);
   endtask

   always @(negedge clk) begin : mon_a
      exp_t e;
      if (done_ok_a || done_fail_a) begin
         if (q_a.size() == 0) begin
            check("done_a_spurious", 1, 0);
         end else begin
            e = q_a.pop_front();
            check("a_done_ok", int'(done_ok_a), int'(e.ok));
            check("a_done_fail", int'(done_fail_a), int'(!e.ok));
            check("a_change", int'(change_a), e.change);
            check("a_paid", int'(paid_a), e.paid);
            check("a_ones", int'(ones_a), e.paid % 10);
            check("a_tens", int'(tens_a), (e.paid / 10) % 10);
            check("a_hund", int'(hund_a), e.paid / 100);
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (done_ok_b || done_fail_b) begin
         if (q_b.size() == 0) begin
            check("done_b_spurious", 1, 0);
         end else begin
            e = q_b.pop_front();
            check("b_done_ok", int'(done_ok_b), int'(e.ok));
            check("b_done_fail", int'(done_fail_b), int'(!e.ok));
            check("b_change", int'(change_b), e.change);
            check("b_paid", int'(paid_b), e.paid);
            check("b_ones", int'(ones_b), e.paid % 10);
            check("b_tens", int'(tens_b), (e.paid / 10) % 10);
            check("b_hund", int'(hund_b), e.paid / 100);
         end
      end
   end

   task automatic check_zero_a(input string tag);
      check({tag, "_busy"}, int'(busy_a), 0);
      check({tag, "_paid"}, int'(paid_a), 0);
      check({tag, "_change"}, int'(change_a), 0);
      check({tag, "_remain"}, int'(remain_a), 0);
      check({tag, "_rej"}, int'(coin_reject_a), 0);
      check({tag, "_ok"}, int'(done_ok_a), 0);
      check({tag, "_fail"}, int'(done_fail_a), 0);
      check({tag, "_digits"}, int'({hund_a, tens_a, ones_a}), 0);
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
      drive(1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
      repeat (3) cycle();
      rst = 1'b0;
      check_zero_a("rst_a");
      check("rst_b_busy", int'(busy_b), 0);
      check("rst_b_paid", int'(paid_b), 0);

      // Auto-finish as soon as the price is covered.
      start_s(0, 15);
      coin(0, 5); coin(0, 5); coin(0, 10);
      wait_idle(0);

      // Timeout with too little paid.
      start_s(0, 20);
      coin(0, 5); coin(0, 5);
      ticks(0, 30);
      wait_idle(0);

      // Cancel-only settlement, both outcomes.
      start_s(1, 20);
      coin(1, 10); coin(1, 10); coin(1, 5);
      cancel_s(1);
      wait_idle(1);
      start_s(1, 20);
      coin(1, 5);
      cancel_s(1);
      wait_idle(1);

      // Overflow refusal at the 6-bit ceiling.
      start_s(1, 20);
      coin(1, 15); coin(1, 15); coin(1, 15); coin(1, 15);
      coin(1, 7);
      coin(1, 3);
      cancel_s(1);
      wait_idle(1);

      // Coin, cancel and timeout together.
      start_s(0, 20);
      coin(0, 5); coin(0, 5); coin(0, 5);
      ticks(0, 29);
      combo(0, 5);
      wait_idle(0);

      // Zero price settles immediately.
      start_s(0, 0);
      wait_idle(0);

      // Reset mid-session discards it without a done pulse.
      start_s(0, 50);
      coin(0, 5); coin(0, 7);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check_zero_a("midrst");
      repeat (4) cycle();

      // start during a session is ignored, price stays latched.
      start_s(0, 20);
      coin(0, 5);
      drive(0, 1'b1, 3, 1'b0, 0, 1'b0, 1'b0);
      cycle();
      drive(0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
      check("ign_start_busy", int'(busy_a), 1);
      check("ign_start_paid", int'(paid_a), 5);
      check("ign_start_remain", int'(remain_a), 30);
      cancel_s(0);
      wait_idle(0);

      start_s(0, 10);
      coin(0, 10);
      wait_idle(0);

      repeat (3) cycle();
      check("q_a_empty", q_a.size(), 0);
      check("q_b_empty", q_b.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
